// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, word geometry.
package lsu_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      RESP = 2'b11
   } state_e;

endpackage

// File: rtl/lsu_mem_master_if.sv
// Core request/response and data-memory port bundle for lsu_mem_master.
interface lsu_mem_if #(parameter int ADDR_W = 32);

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wd;
   logic              mem_we;
   logic [31:0]       mem_rd;

   modport master (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wd, mem_we
   );

   modport slave (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wd, mem_we
   );

endinterface

// File: rtl/lsu_lane_unit.sv
// Byte/half lane handling: load extract with sign/zero extend, and sub-word store merge.
module lsu_lane_unit
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  size_e       size,
   input  logic        sgn,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v     = word[{lane, 3'b000} +: 8];
      half_v     = lane[1] ? word[31:16] : word[15:0];
      load_data  = word;
      store_word = wdata;
      // A misaligned half simply uses addr[1]; word accesses ignore the lane.
      case (size)
         SZ_B: begin
            load_data  = {{24{sgn & byte_v[7]}}, byte_v};
            store_word = word;
            store_word[{lane, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_H: begin
            load_data  = {{16{sgn & half_v[15]}}, half_v};
            store_word = word;
            if (lane[1]) store_word[31:16] = wdata[15:0];
            else         store_word[15:0]  = wdata[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit driving a word-only data memory; sub-word stores are read-modify-write.
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int MEM_WORDS = 64
)(
   input  logic clk,
   input  logic reset,
   lsu_mem_if.master bus
);

   // state | meaning
   // IDLE  | req_ready high, waiting for a request
   // RD    | memory word read (load data, or old word for sub-word store)
   // WR    | single-cycle memory write (mem_we high)
   // RESP  | resp_valid pulse with rdata/err

   state_e            state;
   logic              r_we;
   size_e             r_size;
   logic              r_sgn;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              accept;
   logic              req_err;
   logic [ADDR_W-1:0] word_addr;
   logic [31:0]       load_data;
   logic [31:0]       store_word;

   assign accept    = bus.req_valid & bus.req_ready;
   assign word_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};

   always_comb begin
      req_err = ({2'b00, bus.req_addr[ADDR_W-1:2]} >= ADDR_W'(MEM_WORDS))
                || (bus.req_size == SZ_X);
`ifdef LSU_MISALIGN_TRAP_EN
      if (bus.req_size == SZ_H && bus.req_addr[0])          req_err = 1'b1;
      if (bus.req_size == SZ_W && bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
   end

   lsu_lane_unit u_lane (
      .word       (bus.mem_rd),
      .lane       (r_addr[1:0]),
      .size       (r_size),
      .sgn        (r_sgn),
      .wdata      (r_wdata),
      .load_data  (load_data),
      .store_word (store_word)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         r_we           <= 1'b0;
         r_size         <= SZ_B;
         r_sgn          <= 1'b0;
         r_addr         <= '0;
         r_wdata        <= '0;
         bus.req_ready  <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_err   <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wd     <= '0;
         bus.mem_we     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               r_we          <= bus.req_we;
               r_size        <= size_e'(bus.req_size);
               r_sgn         <= bus.req_signed;
               r_addr        <= bus.req_addr;
               r_wdata       <= bus.req_wdata;
               bus.req_ready <= 1'b0;
               if (req_err) begin
                  state          <= RESP;
                  bus.resp_valid <= 1'b1;
                  bus.resp_err   <= 1'b1;
               end else if (bus.req_we && bus.req_size == SZ_W) begin
                  state        <= WR;
                  bus.mem_addr <= word_addr;
                  bus.mem_wd   <= bus.req_wdata;
                  bus.mem_we   <= 1'b1;
               end else begin
                  state        <= RD;
                  bus.mem_addr <= word_addr;
               end
            end
            RD: begin
               // mem_addr stays put for the RMW write phase.
               if (r_we) begin
                  state      <= WR;
                  bus.mem_wd <= store_word;
                  bus.mem_we <= 1'b1;
               end else begin
                  state          <= RESP;
                  bus.mem_addr   <= '0;
                  bus.resp_valid <= 1'b1;
                  bus.resp_rdata <= load_data;
               end
            end
            WR: begin
               state          <= RESP;
               bus.mem_we     <= 1'b0;
               bus.mem_addr   <= '0;
               bus.mem_wd     <= '0;
               bus.resp_valid <= 1'b1;
            end
            RESP: begin
               state          <= IDLE;
               bus.resp_valid <= 1'b0;
               bus.resp_err   <= 1'b0;
               bus.resp_rdata <= '0;
               bus.req_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
Load/store unit that acts as initiator on the word-addressed data-memory port: combinational read data, write on clock edge when write-enable is high.
- Accepts byte/half/word load and store requests from the core over a valid/ready handshake.
- Performs sign/zero extension on loads.
- Performs sub-word stores as read-modify-write against the word-only memory.
- Sits between the processor datapath and the data memory.

Parameters:
ADDR_W, 32, byte address width on request and memory sides
MEM_WORDS, 64, number of 32-bit words in the attached memory; used for range checking

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous reset, active-low (0 = reset)
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  sign-extend load result (ignored for word and for stores)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle pulse: request completed
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  qualifies resp_valid: request rejected
mem_addr  out  ADDR_W  word-aligned byte address to memory (bits [1:0] always 0)
mem_wd  out  32  write data to memory
mem_we  out  1  memory write enable
mem_rd  in  32  memory read data (combinational from mem_addr)

Behaviour:
- States: IDLE, RD (read phase), WR (write phase), RESP.
- Reset (reset=0, async) forces IDLE. While in reset:
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_we=0, mem_addr=0, mem_wd=0.
  - All request registers cleared.
- Handshake:
  - Accept when req_valid & req_ready at a rising edge; latch we/size/signed/addr/wdata.
  - req_ready is 1 only in IDLE, so no request is accepted in RD/WR/RESP.
  - No response back-pressure: resp_valid is high exactly one cycle, in RESP.
- Error check at accept, always on: word index addr[ADDR_W-1:2] >= MEM_WORDS, or size==11, is an error.
  - Error path: IDLE -> RESP with resp_err=1, rdata=0. No memory cycle.
- Load: IDLE -> RD -> RESP.
  - In RD: mem_addr={addr[ADDR_W-1:2],00}, mem_we=0; capture mem_rd at end of RD.
  - Lane select by addr[1:0]: byte lane = addr[1:0]; half lane = addr[1].
  - Extend to 32 bits (sign if req_signed, else zero).
  - Latency: resp_valid two cycles after the accept edge.
- Word store: IDLE -> WR -> RESP.
  - mem_we=1 for exactly one cycle (WR), mem_wd=wdata.
- Sub-word store: IDLE -> RD -> WR -> RESP.
  - RD captures the old word.
  - WR writes the merged word: only the addressed byte or half is replaced by wdata[7:0] or wdata[15:0]; other bytes keep their old value.
  - mem_addr is held constant across RD and WR.
- RESP -> IDLE unconditionally. A new request can be accepted on the edge leaving RESP+1, i.e. the first cycle back in IDLE.
- mem_we is 0 in every state except WR.
- mem_addr and mem_wd are 0 in IDLE and RESP.
- Reset asserted during WR aborts immediately: mem_we falls asynchronously. A partial RMW is never completed; the memory keeps its old word.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=00, is an error (resp_err=1, no memory access).
- Undefined: misalignment is ignored.
  - The low address bits that would be misaligned are treated as 0: half uses addr[1], word uses lane 0.
  - The access proceeds normally.
  - resp_err is set only by the range/illegal-size check.

Decomposition:
- Shared package lsu_pkg holds:
  - Size encodings: SZ_B, SZ_H, SZ_W.
  - State encoding: IDLE, RD, WR, RESP.
  - Constant WORD_BYTES=4.
- One natural sub-module, lsu_lane_unit (combinational), containing:
  - Load extract/extend, from word, addr[1:0], size, signed.
  - Store merge, from old word, wdata, addr[1:0], size.

Test Plan:
- Memory word 1 = 0x8899AABB. Byte load addr 0x5, signed -> resp_rdata=0xFFFFFFAA on the cycle two cycles after accept; unsigned -> 0x000000AA.
- Word 2 = 0x11223344. Byte store 0xEE at addr 0xA -> RD, WR with mem_wd=0x11EE3344 and mem_we high exactly one cycle; resp_valid on the third cycle after accept.
- Word store 0xCAFEF00D to addr 0x10 -> single WR cycle, mem_addr=0x10; a follow-up word load returns 0xCAFEF00D.
- Load at addr 0x100 (index 64 >= MEM_WORDS) -> resp_err=1, resp_rdata=0, mem_we never high.
- Half load addr 0x3, macro defined -> resp_err=1. Macro undefined -> returns upper half of word 0, no error.
- Sub-word store in flight, reset pulled low during WR -> mem_we=0 immediately, target word unchanged, req_ready=1 after reset released.
